bcd_display_formatter: RTL and testbench
========================================

# bcd_display_formatter

Sequential binary-to-display formatter that sits directly upstream of the four-digit seven-segment renderer. It accepts a 16-bit unsigned result through a valid/ready handshake. It converts the result to four decimal digits with an iterative shift-add-3 (double-dabble) datapath, one bit per clock. It then drives the renderer's 16-bit `graphics` word with digit codes, blank codes or the "Err" glyph pattern.

## Interface
- No parameters; width fixed at 16-bit input, 4 digits out.
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_value`  input  16  unsigned binary value to display.
- `in_err`  input  1  force "Err" display regardless of `in_value`.
- `in_valid`  input  1  `in_value`/`in_err` valid this cycle.
- `in_ready`  output  1  formatter idle, can accept.
- `graphics`  output  16  renderer word; [15:12] leftmost digit, [3:0] rightmost; nibble codes 0–9 digits, 4'hD 'E', 4'hB 'r', 4'hF off.
- `out_done`  output  1  one-cycle pulse: `graphics` just updated.

## Operation
- States: IDLE, CONVERT, FORMAT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: capture `in_value` into 16-bit shift reg; clear 16-bit BCD accumulator and 5-bit bit counter.
  - Latch err flag = `in_err` OR (`in_value` > 9999).
  - Go to CONVERT.
- CONVERT, one iteration per clock:
  - Each BCD nibble ≥5 gets +3, then {BCD, shift} shifts left 1.
  - After 16 iterations (counter 15→16), go to FORMAT.
  - Accumulator uses 4 nibbles; bits above 9999 are discarded; overflow is covered by the err flag.
- FORMAT, one clock:
  - Err flag set: `graphics` ← 16'hFDBB ("␣Err", right-aligned).
  - Otherwise `graphics` ← BCD digits, with leading-zero blanking per Configuration.
  - Rightmost digit is never blanked.
  - Pulse `out_done`; return to IDLE.
- `graphics` holds its value between conversions. It changes only in FORMAT or on reset.
- `in_valid` while `in_ready`=0 is ignored, not queued. The upstream source must hold or re-present the value.
- `in_value` changes after acceptance have no effect on the conversion in flight.

## Timing
- Reset values: `graphics`=16'hFFFF (all segments off), `in_ready`=1, `out_done`=0, state IDLE.
- Accept edge A0 (IDLE, `in_valid`=1). CONVERT occupies edges A1..A16. FORMAT is edge A17.
- `graphics` and `out_done` are valid after A17; `out_done` is high exactly one cycle.
- `in_ready` is low after A0 through A17 and high after A17.
- Fixed latency: 17 clocks from accept to new `graphics`. Throughput: one value per 18 clocks.
- Back-to-back: `in_valid` held high re-accepts on the edge after the `out_done` cycle (A18).
- `rst` asserted mid-CONVERT or mid-FORMAT:
  - Conversion is aborted and `graphics` returns to 16'hFFFF on that edge.
  - No `out_done` is produced.
  - `rst` has priority over `in_valid` in the same cycle.
- Value 9999 displays normally. Value 10000 shows "Err". Values 0–9999 never raise the err flag.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - Each leading zero nibble left of the first nonzero digit becomes 4'hF.
  - Digit 0 is always shown, so value 0 → 16'hFFF0 and 42 → 16'hFF42.
- Undefined: all four digits are shown, so 0 → 16'h0000 and 42 → 16'h0042.
- The Err pattern is the same with and without the macro.

## Test plan
- Reset, then idle 5 cycles → `graphics`=16'hFFFF, `in_ready`=1, `out_done`=0.
- Accept 1234 → exactly 17 clocks later `graphics`=16'h1234, one-cycle `out_done`, `in_ready` high next cycle.
- Accept 0, then 42, then 9999:
  - With macro → 16'hFFF0, 16'hFF42, 16'h9999.
  - Without macro → 16'h0000, 16'h0042, 16'h9999.
- Accept 10000, and separately 7 with `in_err`=1 → both give 16'hFDBB. 65535 → 16'hFDBB.
- Accept 5678, then pulse `in_valid` with 1111 at A5 → pulse ignored, `graphics`=16'h5678. `in_valid` held from A17 → 1111 accepted at A18, displayed after A35.
- Accept 8000, assert `rst` at A9 → `graphics`=16'hFFFF, no `out_done`. Next accept of 3 → 16'hFFF3 with macro, 16'h0003 without.

Source files
------------

// File: rtl/bcd_display_formatter.sv
// 16-bit binary to 4-digit BCD display formatter (iterative double-dabble, one bit per clock).
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_display_formatter (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_value,
    input  logic        in_err,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] graphics,
    output logic        out_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FORMAT  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [15:0] shreg;
    logic [15:0] bcd;
    logic [15:0] bcd_adj;
    logic [31:0] shifted;
    logic [4:0]  cnt;
    logic        err;
    logic [15:0] formatted;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = CONVERT;
            CONVERT: if (cnt == 5'd15) state_next = FORMAT;
            FORMAT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction per nibble, then shift the combined {bcd, shreg} left by one
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        shifted = {bcd_adj, shreg} << 1;
    end

    always_comb begin
        in_ready  = (state == IDLE);
        formatted = bcd;
`ifdef LEADING_ZERO_BLANK_EN
        // Blanking propagates rightward only while every digit to the left was also blanked
        if (bcd[15:12] == 4'd0) begin
            formatted[15:12] = 4'hF;
            if (bcd[11:8] == 4'd0) begin
                formatted[11:8] = 4'hF;
                if (bcd[7:4] == 4'd0)
                    formatted[7:4] = 4'hF;
            end
        end
`else
        formatted = bcd;
`endif
        if (err)
            formatted = 16'hFDBB;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            graphics <= '1;
            out_done <= 1'b0;
            shreg    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            err      <= 1'b0;
        end else begin
            out_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= in_value;
                        bcd   <= '0;
                        cnt   <= '0;
                        err   <= in_err | (in_value > 16'd9999);
                    end
                end
                CONVERT: begin
                    bcd   <= shifted[31:16];
                    shreg <= shifted[15:0];
                    cnt   <= cnt + 5'd1;
                end
                FORMAT: begin
                    graphics <= formatted;
                    out_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Directed self-checking bench for bcd_display_formatter; expectations follow LEADING_ZERO_BLANK_EN.
module tb_bcd_display_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_value;
    logic        in_err;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] graphics;
    logic        out_done;

    int tests = 0;
    int fails = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [15:0] EXP_0   = 16'hFFF0;
    localparam logic [15:0] EXP_42  = 16'hFF42;
    localparam logic [15:0] EXP_3   = 16'hFFF3;
    localparam logic [15:0] EXP_10  = 16'hFF10;
    localparam logic [15:0] EXP_100 = 16'hF100;
`else
    localparam logic [15:0] EXP_0   = 16'h0000;
    localparam logic [15:0] EXP_42  = 16'h0042;
    localparam logic [15:0] EXP_3   = 16'h0003;
    localparam logic [15:0] EXP_10  = 16'h0010;
    localparam logic [15:0] EXP_100 = 16'h0100;
`endif

    bcd_display_formatter dut (
        .clk      (clk),
        .rst      (rst),
        .in_value (in_value),
        .in_err   (in_err),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .graphics (graphics),
        .out_done (out_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one value, scramble the input after acceptance, and check the fixed 17-clock latency
    task automatic convert(input string tag, input logic [15:0] value, input logic e,
                           input logic [15:0] exp, input logic [15:0] prev);
        in_value = value;
        in_err   = e;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_value = ~value;
        in_err   = ~e;
        check({tag, "_busy"}, {15'd0, in_ready}, 16'd0);
        for (int i = 1; i <= 16; i++) begin
            step();
            check({tag, "_nodone"}, {15'd0, out_done}, 16'd0);
        end
        check({tag, "_hold"}, graphics, prev);
        step();
        check({tag, "_gfx"}, graphics, exp);
        check({tag, "_done"}, {15'd0, out_done}, 16'd1);
        check({tag, "_ready"}, {15'd0, in_ready}, 16'd1);
        in_err = 1'b0;
        step();
        check({tag, "_pulse"}, {15'd0, out_done}, 16'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_value = '0;
        in_err   = 1'b0;
        in_valid = 1'b1;
        step();
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("rst_gfx", graphics, 16'hFFFF);
        check("rst_ready", {15'd0, in_ready}, 16'd1);
        check("rst_done", {15'd0, out_done}, 16'd0);

        convert("v1234", 16'd1234, 1'b0, 16'h1234, 16'hFFFF);
        convert("v0", 16'd0, 1'b0, EXP_0, 16'h1234);
        convert("v42", 16'd42, 1'b0, EXP_42, EXP_0);
        convert("v9999", 16'd9999, 1'b0, 16'h9999, EXP_42);
        convert("v10000", 16'd10000, 1'b0, 16'hFDBB, 16'h9999);
        convert("v10", 16'd10, 1'b0, EXP_10, 16'hFDBB);
        convert("v7err", 16'd7, 1'b1, 16'hFDBB, EXP_10);
        convert("v100", 16'd100, 1'b0, EXP_100, 16'hFDBB);
        convert("v65535", 16'd65535, 1'b0, 16'hFDBB, EXP_100);

        // 5678 with a stray pulse at A5, then 1111 held from A17 and accepted at A18
        in_value = 16'd5678;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) step();
        in_value = 16'd1111;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("pulse_busy", {15'd0, in_ready}, 16'd0);
        for (int i = 6; i <= 16; i++) step();
        in_value = 16'd1111;
        in_valid = 1'b1;
        step();
        check("b2b_gfx1", graphics, 16'h5678);
        check("b2b_done1", {15'd0, out_done}, 16'd1);
        step();
        in_valid = 1'b0;
        in_value = 16'd4321;
        check("b2b_accept", {15'd0, in_ready}, 16'd0);
        for (int i = 1; i <= 16; i++) step();
        check("b2b_hold", graphics, 16'h5678);
        step();
        check("b2b_gfx2", graphics, 16'h1111);
        check("b2b_done2", {15'd0, out_done}, 16'd1);
        step();

        // Reset at A9 aborts the conversion of 8000
        in_value = 16'd8000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) step();
        rst = 1'b1;
        in_valid = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check("abort_gfx", graphics, 16'hFFFF);
        check("abort_ready", {15'd0, in_ready}, 16'd1);
        check("abort_done", {15'd0, out_done}, 16'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("abort_nodone", {15'd0, out_done}, 16'd0);
        end
        check("abort_gfx_hold", graphics, 16'hFFFF);
        convert("v3", 16'd3, 1'b0, EXP_3, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
